rice_core_if_stage: RTL and testbench

Instruction-fetch stage of the rice core: owns the program counter, issues fetch requests on a valid/ready instruction bus, buffers returned instructions and presents them to the decode stage as `if_result`. It sits at the head of the pipeline, drives `if_result` in `rice_core_pipeline_if` and obeys `stall`/`flush`/`flush_pc` from the execute stage. Redirects discard all in-flight fetches.

---
 rtl/rice_core_pkg.sv | 27 ++
 rtl/rice_core_pipeline_if.sv | 19 +
 rtl/rice_core_if_fifo.sv | 70 +++++++
 rtl/rice_core_if_stage.sv | 172 +++++++++++++++++
 tb/tb_rice_core_if_stage.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rice_core_pkg.sv
// rice_core_pkg: shared types for the rice core pipeline.
//   rice_core_pc        - program counter / address (RICE_CORE_XLEN bits)
//   rice_core_inst      - 32-bit instruction word
//   rice_core_if_result - fetch stage result {valid, pc, inst}
//   RICE_CORE_NOP       - canonical no-op encoding (addi x0, x0, 0)
// The type set is generated by `RICE_CORE_DEFINE_TYPES so that the
// same declarations can be reproduced with another address width.

`ifndef RICE_CORE_PKG_TYPES_DEFINED
`define RICE_CORE_PKG_TYPES_DEFINED
`define RICE_CORE_DEFINE_TYPES(PW) \
  typedef logic [PW-1:0] rice_core_pc; \
  typedef logic [31:0] rice_core_inst; \
  typedef struct packed { \
    logic          valid; \
    rice_core_pc   pc; \
    rice_core_inst inst; \
  } rice_core_if_result;
`endif

package rice_core_pkg;
  localparam int RICE_CORE_XLEN = 32;

  `RICE_CORE_DEFINE_TYPES(RICE_CORE_XLEN)

  localparam rice_core_inst RICE_CORE_NOP = 32'h0000_0013;
endpackage

// File: rtl/rice_core_pipeline_if.sv
// rice_core_pipeline_if: control/result bundle between the fetch stage
// and the execute stage.
//   stall     - execute cannot accept a new instruction; fetch holds its output
//   flush     - redirect; discards everything fetched so far
//   flush_pc  - target address of the redirect
//   if_result - instruction presented by the fetch stage
// Modports: if_stage (fetch side), ex_stage (execute side).

interface rice_core_pipeline_if;
  import rice_core_pkg::*;

  logic               stall;
  logic               flush;
  rice_core_pc        flush_pc;
  rice_core_if_result if_result;

  modport if_stage (input stall, input flush, input flush_pc, output if_result);
  modport ex_stage (output stall, output flush, output flush_pc, input if_result);
endinterface

// File: rtl/rice_core_if_fifo.sv
// rice_core_if_fifo: synchronous FIFO, DEPTH entries (power of two) of WIDTH bits.
//   clk, rst       - clock, synchronous active-high reset (pointers only)
//   push, din      - write din when push (ignored when full and not popping)
//   pop, dout      - dout is the head entry; pop removes it (ignored when empty)
//   clear          - empties the FIFO, overrides push/pop
//   count          - number of stored entries
//   empty, full    - status flags

module rice_core_if_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop) && !clear;
    do_pop   = pop && !empty && !clear;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/rice_core_if_stage.sv
// rice_core_if_stage: instruction fetch stage of the rice core.
// Owns the fetch PC, issues word fetches on a valid/ready bus, buffers the
// in-order responses and presents them to decode through pipeline_if.
//   i_clk, i_rst        - clock, synchronous active-high reset
//   pipeline_if         - if_stage modport: stall/flush/flush_pc in, if_result out
//   o_inst_req_valid    - fetch request valid (held until accepted or flushed)
//   i_inst_req_ready    - bus accepts the request
//   o_inst_req_pc       - word-aligned fetch address
//   i_inst_resp_valid   - response valid (in order, never back-pressured)
//   i_inst_resp_data    - instruction word
// Optional (macro RICE_CORE_IF_PERF_EN):
//   o_fetch_count       - accepted requests, saturating
//   o_bubble_count      - cycles with !stall and an empty next if_result, saturating

module rice_core_if_stage
  import rice_core_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              FETCH_DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  rice_core_pipeline_if.if_stage pipeline_if,
  output logic                   o_inst_req_valid,
  input  logic                   i_inst_req_ready,
  output logic [XLEN-1:0]        o_inst_req_pc,
  input  logic                   i_inst_resp_valid,
  input  logic [31:0]            i_inst_resp_data
`ifdef RICE_CORE_IF_PERF_EN
  ,
  output logic [31:0]            o_fetch_count,
  output logic [31:0]            o_bubble_count
`endif
);
  localparam int CW = $clog2(FETCH_DEPTH) + 1;
  localparam int FW = XLEN + 32;

  logic               stall, flush;
  logic [XLEN-1:0]    flush_pc;
  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    resp_pc_q, resp_pc_d;
  logic [CW-1:0]      outstanding_q, outstanding_d;
  logic [CW-1:0]      drop_q, drop_d;
  rice_core_if_result if_result_q, if_result_d;
  logic               accept, resp_any, resp_keep;
  logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]      fifo_count;
  logic [FW-1:0]      fifo_din, fifo_dout;

  assign stall    = pipeline_if.stall;
  assign flush    = pipeline_if.flush;
  assign flush_pc = XLEN'(pipeline_if.flush_pc);

  assign pipeline_if.if_result = if_result_q;
  assign o_inst_req_pc         = fetch_pc_q;
  assign fifo_din              = {resp_pc_q, i_inst_resp_data};

  // Request / bus bookkeeping.
  // outstanding_q counts every request still owed a response, including
  // ones already condemned by a flush; drop_q says how many of the oldest
  // of those must be thrown away. Gating new requests on the full count
  // keeps drop_q bounded by FETCH_DEPTH even under back-to-back redirects.
  always_comb begin
    o_inst_req_valid = !i_rst && !flush && !fifo_full &&
                       ((CW+1)'(outstanding_q) + (CW+1)'(fifo_count) < (CW+1)'(FETCH_DEPTH));
    accept    = o_inst_req_valid && i_inst_req_ready;
    resp_any  = i_inst_resp_valid && (outstanding_q != '0);
    resp_keep = resp_any && !flush && (drop_q == '0);

    outstanding_d = outstanding_q + CW'(accept) - CW'(resp_any);

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    if (flush) begin
      fetch_pc_d = flush_pc;
      resp_pc_d  = flush_pc;
      drop_d     = outstanding_d;
    end else begin
      if (accept)                       fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_keep)                    resp_pc_d  = resp_pc_q + XLEN'(4);
      if (resp_any && drop_q != '0)     drop_d     = drop_q - CW'(1);
    end
  end

  // Output register. When the buffer is empty a kept response bypasses
  // straight into if_result so a zero-wait bus sustains one per cycle.
  always_comb begin
    if_result_d = if_result_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    if (flush) begin
      if_result_d.valid = 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        if_result_d.valid = 1'b1;
        if_result_d.pc    = rice_core_pc'(fifo_dout[FW-1:32]);
        if_result_d.inst  = fifo_dout[31:0];
        fifo_pop          = 1'b1;
        fifo_push         = resp_keep;
      end else if (resp_keep) begin
        if_result_d.valid = 1'b1;
        if_result_d.pc    = rice_core_pc'(resp_pc_q);
        if_result_d.inst  = i_inst_resp_data;
      end else begin
        if_result_d.valid = 1'b0;
      end
    end else begin
      fifo_push = resp_keep;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      if_result_q   <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      if_result_q   <= if_result_d;
    end
  end

  rice_core_if_fifo #(
    .DEPTH (FETCH_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .clear (flush),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

`ifdef RICE_CORE_IF_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction

  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    fetch_count_d  = sat_inc(fetch_count_q, accept);
    bubble_count_d = sat_inc(bubble_count_q, !stall && !if_result_d.valid);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign o_fetch_count  = fetch_count_q;
  assign o_bubble_count = bubble_count_q;
`endif
endmodule

// File: tb/tb_rice_core_if_stage.sv
`timescale 1ns/1ps
module tb_rice_core_if_stage;
  import rice_core_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, resp_valid;
  logic [31:0] req_pc, resp_data;
  logic        stall, flush;
  logic [31:0] flush_pc;
`ifdef RICE_CORE_IF_PERF_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  always #5 clk = ~clk;

  rice_core_pipeline_if pif();
  assign pif.stall    = stall;
  assign pif.flush    = flush;
  assign pif.flush_pc = flush_pc;

  rice_core_if_stage #(
    .XLEN        (32),
    .RESET_PC    (32'h0),
    .FETCH_DEPTH (DEPTH)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .pipeline_if       (pif),
    .o_inst_req_valid  (req_valid),
    .i_inst_req_ready  (req_ready),
    .o_inst_req_pc     (req_pc),
    .i_inst_resp_valid (resp_valid),
    .i_inst_resp_data  (resp_data)
`ifdef RICE_CORE_IF_PERF_EN
    ,
    .o_fetch_count     (fetch_count),
    .o_bubble_count    (bubble_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Memory content seen by the bus: distinct from the address itself.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0013;
  endfunction

  // ---------------- bus model: in-order responses with latency ----------------
  typedef struct { logic [31:0] pc; int due; } bus_t;
  bus_t bus_q[$];
  int   cyc = 0;
  int   last_due = 0;
  int   lat_min = 1, lat_max = 1;

  always @(posedge clk) begin : bus_drv
    cyc = cyc + 1;
    #2;
    if (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = inst_of(bus_q[0].pc);
      void'(bus_q.pop_front());
    end else begin
      resp_valid = 1'b0;
      resp_data  = $urandom;
    end
  end

  // ---------------- behavioural model + compare ----------------
  // Since the last redirect, decode must see flush_pc, +4, +8 ... with
  // nothing lost or repeated; a stalled output is frozen; a flushed output
  // is empty; requests walk the same sequence and hold while not accepted.
  logic [31:0]        exp_req_pc = 32'h0, exp_out_pc = 32'h0;
  int                 n_acc = 0, n_del = 0, tot_acc = 0, tot_del = 0, bubbles = 0;
  int                 first_acc = -1, first_val = -1;
  logic               p_rst = 1'b0, p_stall = 1'b0, p_flush = 1'b0, p_valid = 1'b0, p_ready = 1'b0;
  logic [31:0]        p_pc = '0;
  rice_core_if_result p_res = '0;

  always @(negedge clk) begin : cmp
    rice_core_if_result r;
    logic acc;
    int   d;
    r = pif.if_result;
    if (p_rst) chk("reset_if_result", r, '0);
    else if (p_flush) chk("flush_clears_valid", r.valid, 1'b0);
    else if (p_stall) chk("stall_hold", r, p_res);
    else if (r.valid === 1'b1) begin
      chk("out_pc", r.pc, exp_out_pc);
      chk("out_inst", r.inst, inst_of(exp_out_pc));
      exp_out_pc += 32'd4;
      n_del++;
      tot_del++;
      if (first_val < 0) first_val = cyc;
    end
    if (!p_rst && !p_stall && r.valid === 1'b0) bubbles++;
    if (!p_rst && !p_flush) chk("inflight_bound", (n_acc - n_del) <= DEPTH, 1);

    if (rst || flush) chk("req_blocked", req_valid, 1'b0);
    else if (req_valid) chk("req_pc", req_pc, exp_req_pc);
    if (!rst && !flush && !p_rst && !p_flush && p_valid && !p_ready)
      chk("req_held", {req_valid, req_pc}, {1'b1, p_pc});

    acc = req_valid && req_ready && !rst && !flush;
    if (rst) begin
      exp_req_pc = 32'h0; exp_out_pc = 32'h0;
      n_acc = 0; n_del = 0; tot_acc = 0; bubbles = 0;
      bus_q.delete();
      last_due = 0;
    end else if (flush) begin
      exp_req_pc = flush_pc; exp_out_pc = flush_pc;
      n_acc = 0; n_del = 0;
    end else if (acc) begin
      exp_req_pc += 32'd4;
      n_acc++;
      tot_acc++;
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d < last_due) d = last_due;
      last_due = d;
      bus_q.push_back('{req_pc, d});
      if (first_acc < 0) first_acc = cyc;
    end

    p_rst = rst; p_stall = stall; p_flush = flush;
    p_valid = req_valid; p_ready = req_ready; p_pc = req_pc; p_res = r;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name, input int max);
    int i;
    for (i = 0; i < max && pif.if_result.valid !== 1'b1; i++) tick();
    if (i == max) chk(name, 0, 1);
  endtask

  initial begin : timeout
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rice_core_if_result saved;
    int del0;
    stall = 1'b0; flush = 1'b0; flush_pc = '0; req_ready = 1'b1;
    resp_valid = 1'b0; resp_data = '0;

    // Startup with a zero-wait bus: 0,4,8,... one per cycle, latency 2.
    repeat (3) tick();
    rst = 1'b0;
    wait_valid("startup_timeout", 10);
    for (int i = 0; i < 6; i++) begin
      chk("startup_seq_valid", pif.if_result.valid, 1'b1);
      chk("startup_seq_pc", pif.if_result.pc, 32'(i * 4));
      tick();
    end
    chk("first_latency", first_val - first_acc, 2);

    // Stall held for 10 cycles: frozen output, no request when full.
    stall = 1'b1;
    saved = pif.if_result;
    repeat (10) tick();
    chk("stall_frozen", pif.if_result, saved);
    chk("full_no_req", req_valid, 1'b0);
    stall = 1'b0;
    tick();
    chk("resume_pc", pif.if_result.pc, saved.pc + 32'd4);

    // Redirect while responses are in flight on a slow bus.
    lat_min = 4; lat_max = 4;
    repeat (8) tick();
    flush = 1'b1; flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    wait_valid("flush_timeout", 40);
    chk("flush_first_pc", pif.if_result.pc, 32'h100);

    // Flush and stall together: flush wins.
    lat_min = 1; lat_max = 1;
    repeat (6) tick();
    stall = 1'b1; flush = 1'b1; flush_pc = 32'h40;
    tick();
    stall = 1'b0; flush = 1'b0;
    chk("fs_valid0", pif.if_result.valid, 1'b0);
    wait_valid("fs_timeout", 20);
    chk("fs_first_pc", pif.if_result.pc, 32'h40);

    // Ready low for 5 cycles with the third fetch (pc 0x8) pending.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 10 && tot_acc < 2; i++) tick();
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ready_low_req", {req_valid, req_pc}, {1'b1, 32'h8});
    end
    req_ready = 1'b1;
    repeat (4) tick();

    // Randomized traffic, including wrap-around redirects and a mid-run reset.
    lat_min = 1; lat_max = 3;
    del0 = tot_del;
    for (int i = 0; i < 1500; i++) begin
      stall     = ($urandom % 4) == 0;
      req_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 50) == 0;
      flush_pc  = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      rst       = (i == 700 || i == 701);
      if (rst) flush = 1'b0;
      tick();
    end
    stall = 1'b0; flush = 1'b0; req_ready = 1'b1; rst = 1'b0;
    repeat (10) tick();
    chk("random_progress", (tot_del - del0) > 200, 1);

`ifdef RICE_CORE_IF_PERF_EN
    req_ready = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    #1;
    chk("perf_fetch_count", fetch_count, tot_acc);
    chk("perf_bubble_count", bubble_count, bubbles);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
